// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: select codes, FSM states
// and the packed command entry carried through the command FIFO.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_DIV   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_PASSA = 4'd8,
    OP_PASSB = 4'd9,
    OP_SLL   = 4'd10,
    OP_SRL   = 4'd11,
    OP_SRA   = 4'd12,
    OP_INC   = 4'd13,
    OP_DEC   = 4'd14,
    OP_HAM   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

  localparam int CMD_W = 24;

  typedef struct packed {
    logic [3:0] tag;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with extra-bit wrapping pointers; the head entry is always
// visible on o_rdata so a pop and its data use happen in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  w_count;
  logic         w_push;
  logic         w_pop;

  // Pointer difference wraps naturally, giving 0..DEPTH occupancy.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (w_count == (AW + 1)'(DEPTH));
  assign o_empty = (w_count == '0);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, holds the ALU inputs for SETTLE cycles, captures the
// result and returns it with its tag over a valid/ready response channel.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_tag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_tag,
  output logic       rsp_zero,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_res,
  output logic       busy,
  output logic [1:0] o_dbg_state
);
  // Both channels: a transfer happens on a rising edge where valid && ready;
  // valid, once raised, is held with stable payload until that edge.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  seq_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_pend_tag;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CMD_W-1:0] w_head_raw;
  cmd_t             w_head;

  assign w_head      = cmd_t'(w_head_raw);
  assign cmd_ready   = !w_full;
  assign w_push      = cmd_valid && cmd_ready;
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_HOLD && rsp_ready));
  assign busy        = (r_state != ST_IDLE) || !w_empty;
  assign o_dbg_state = r_state;

  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({cmd_tag, cmd_op, cmd_a, cmd_b}),
    .i_pop   (w_pop),
    .o_rdata (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pend_tag <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      // A pop only happens from IDLE or on the HOLD handshake; ALU inputs
      // otherwise keep their last values between commands.
      if (w_pop) begin
        alu_a      <= w_head.a;
        alu_b      <= w_head.b;
        alu_sel    <= w_head.op;
        r_pend_tag <= w_head.tag;
        r_cnt      <= CNT_INIT;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_DRIVE;
        end
        ST_DRIVE: begin
          if (r_cnt == '0) begin
            rsp_data  <= alu_res;
            rsp_zero  <= (alu_res == 8'h00);
            rsp_tag   <= r_pend_tag;
            rsp_valid <= 1'b1;
            r_state   <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= w_empty ? ST_IDLE : ST_DRIVE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and random checks of the ALU command sequencer against a
// behavioural ALU and an in-order response scoreboard.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int EW     = 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [3:0] cmd_op = '0;
  logic [3:0] cmd_tag = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_tag;
  logic       rsp_zero;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_res;
  logic       busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int rsp_count = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .cmd_tag     (cmd_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .rsp_zero    (rsp_zero),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_res     (alu_res),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // Behavioural 8-bit ALU: used both as the DUT's ALU and as the reference.
  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic signed [7:0] sa;
    logic [15:0] prod;
    sa = a;
    prod = a * b;
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_MUL:   return prod[7:0];
      OP_DIV:   return (b == 8'd0) ? 8'hFF : a / b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_NOT:   return ~a;
      OP_PASSA: return a;
      OP_PASSB: return b;
      OP_SLL:   return a << b[2:0];
      OP_SRL:   return a >> b[2:0];
      OP_SRA:   return 8'(sa >>> b[2:0]);
      OP_INC:   return a + 8'd1;
      OP_DEC:   return a - 8'd1;
      default:  return 8'($countones(a));
    endcase
  endfunction

  assign alu_res = ref_alu(alu_sel, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / protocol monitor ----------------
  logic [7:0]    mon_r;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_rsp = '0;
  logic [EW-1:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        mon_r = ref_alu(cmd_op, cmd_a, cmd_b);
        exp_q.push_back({cmd_tag, mon_r == 8'h00, mon_r});
      end
      if (prev_stall) begin
        check("rsp_hold_valid", rsp_valid, 1);
        check("rsp_hold_stable", {rsp_tag, rsp_zero, rsp_data}, prev_rsp);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        check("rsp_expected_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check("rsp_scoreboard", {rsp_tag, rsp_zero, rsp_data}, mon_exp);
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rsp   = {rsp_tag, rsp_zero, rsp_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] tag);
    bit ok;
    ok = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    cmd_valid = 1'b0;
    check("cmd_accepted", ok, 1);
  endtask

  task automatic wait_rsp(output logic [7:0] d, output logic [3:0] t, output logic z);
    bit ok;
    ok = 1'b0; d = '0; t = '0; z = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ok = 1'b1; d = rsp_data; t = rsp_tag; z = rsp_zero;
        break;
      end
    end
    check("rsp_arrived", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_cmd_ready"}, cmd_ready, 1);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_data"}, rsp_data, 0);
    check({pfx, "_rsp_tag"}, rsp_tag, 0);
    check({pfx, "_rsp_zero"}, rsp_zero, 0);
    check({pfx, "_alu_a"}, alu_a, 0);
    check({pfx, "_alu_b"}, alu_b, 0);
    check({pfx, "_alu_sel"}, alu_sel, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_state"}, dbg_state, 2'(ST_IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0]  d;
  logic [3:0]  t;
  logic        z;
  int          n;
  bit          ok;
  bit          saw;
  logic [EW-1:0] snap;
  logic [19:0] st_cmd [8];
  logic [7:0]  st_res [8];
  logic [19:0] hist [SETTLE+1];
  int          got;
  int          last_cyc;
  int          rand_base;
  logic [3:0]  rop;

  initial begin
    st_cmd = '{{4'd2, 8'h03, 8'h05}, {4'd10, 8'h01, 8'h03}, {4'd15, 8'hFF, 8'h00},
               {4'd4, 8'hF0, 8'h3C}, {4'd3, 8'h64, 8'h07}, {4'd12, 8'h80, 8'h02},
               {4'd7, 8'h0F, 8'h00}, {4'd13, 8'hFF, 8'h00}};
    st_res = '{8'h0F, 8'h08, 8'h08, 8'h30, 8'h0E, 8'hE0, 8'hF0, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single command and latency
    rsp_ready = 1'b1;
    send_cmd(4'(OP_ADD), 8'h12, 8'h34, 4'd3);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) begin n = k; break; end
    end
    check("lat_cycles", n, SETTLE + 1);
    check("single_data", rsp_data, 8'h46);
    check("single_tag", rsp_tag, 4'd3);
    check("single_zero", rsp_zero, 0);
    @(posedge clk); #1;

    // Zero flag
    send_cmd(4'(OP_XOR), 8'h5A, 8'h5A, 4'd1);
    wait_rsp(d, t, z);
    check("xor_data", d, 8'h00);
    check("xor_zero", z, 1);
    check("xor_tag", t, 4'd1);
    send_cmd(4'(OP_SUB), 8'h10, 8'h20, 4'd2);
    wait_rsp(d, t, z);
    check("sub_data", d, 8'hF0);
    check("sub_zero", z, 0);

    // Backpressure capacity and ordering
    rsp_ready = 1'b0;
    n = 0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cmd_op = 4'(OP_ADD); cmd_a = 8'(n); cmd_b = 8'h01; cmd_tag = 4'(n);
      @(negedge clk);
      if (!cmd_ready) break;
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_accepted", n, DEPTH + 1);
    snap = {rsp_tag, rsp_zero, rsp_data};
    repeat (6) begin @(posedge clk); #1; end
    check("bp_stall_stable", {rsp_tag, rsp_zero, rsp_data}, snap);
    check("bp_stall_valid", rsp_valid, 1);
    check("bp_stall_full", cmd_ready, 0);
    check("bp_stall_tag", rsp_tag, 0);
    check("bp_stall_data", rsp_data, 8'h01);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(d, t, z);
      check("bp_order_tag", t, i);
      check("bp_order_data", d, i + 1);
    end

    // Streaming throughput and input stability
    got = 0; last_cyc = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_cmd(st_cmd[i][19:16], st_cmd[i][15:8], st_cmd[i][7:0], 4'(i));
      end
      begin
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
          @(negedge clk);
          for (int j = SETTLE; j > 0; j--) hist[j] = hist[j-1];
          hist[0] = {alu_sel, alu_a, alu_b};
          if (rsp_valid && rsp_ready) begin
            check("stream_tag", rsp_tag, 4'(got));
            check("stream_data", rsp_data, st_res[got]);
            check("stream_zero", rsp_zero, st_res[got] == 8'h00);
            for (int j = 0; j <= SETTLE; j++) check("stream_drive_stable", hist[j], st_cmd[got]);
            if (got > 0) check("stream_interval", cyc - last_cyc, SETTLE + 1);
            last_cyc = cyc;
            got++;
          end
        end
        check("stream_count", got, 8);
      end
    join
    @(posedge clk); #1;

    // Reset during DRIVE with three commands queued
    rsp_ready = 1'b0;
    send_cmd(4'(OP_ADD), 8'h11, 8'h22, 4'd1);
    send_cmd(4'(OP_SUB), 8'h33, 8'h01, 4'd2);
    send_cmd(4'(OP_AND), 8'h77, 8'h0F, 4'd3);
    send_cmd(4'(OP_OR),  8'h40, 8'h04, 4'd4);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    check("rst_pre_hold", ok, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cmd_op = 4'(OP_XOR); cmd_a = 8'h5C; cmd_b = 8'h03; cmd_tag = 4'd5; cmd_valid = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_state", dbg_state, 2'(ST_DRIVE));
    check("rst_pre_busy", busy, 1);
    check("rst_pre_alu_a", alu_a, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    exp_q.delete();
    @(posedge clk); #1;
    check_reset("rst_held");
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw = saw | rsp_valid;
    end
    check("rst_no_stale", saw, 0);
    @(posedge clk); #1;
    send_cmd(4'(OP_ADD), 8'h01, 8'h01, 4'd9);
    wait_rsp(d, t, z);
    check("rst_after_data", d, 8'h02);
    check("rst_after_tag", t, 4'd9);

    // Random traffic: all opcodes, FIFO filling and draining
    rand_base = rsp_count;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          rop = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
          send_cmd(rop, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   4'($urandom_range(0, 15)));
        end
      end
      begin
        for (int cyc = 0; cyc < 6000 && (rsp_count - rand_base) < 200; cyc++) begin
          rsp_ready = ($urandom_range(0, 9) < (((cyc / 40) % 2 == 1) ? 9 : 2));
          @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
      end
    join
    @(posedge clk); #1;
    check("rand_rsp_count", rsp_count - rand_base, 200);
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
